// File: rtl/lsu_pkg.sv
// Shared LSU types: state encoding, core pipeline stage constants, counter sizing.
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_IDLE       = 3'd0,
      LSU_REQUESTING = 3'd1,
      LSU_WAITING    = 3'd2,
      LSU_DONE       = 3'd3,
      LSU_ERROR      = 3'd4
   } lsu_state_e;

   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;

   // Width able to hold 0..timeout; a disabled timeout still gets a 1-bit counter.
   function automatic int unsigned ctr_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory-side request/response bus of the LSU (one read channel, one write channel).
interface lsu_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  mem_read_valid;
   logic [ADDR_WIDTH-1:0] mem_read_address;
   logic                  mem_read_ready;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic                  mem_write_valid;
   logic [ADDR_WIDTH-1:0] mem_write_address;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic                  mem_write_ready;

   modport master (
      output mem_read_valid, mem_read_address,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_write_ready
   );

   modport slave (
      input  mem_read_valid, mem_read_address,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_write_ready
   );
endinterface

// File: rtl/lsu_timeout_ctr.sv
// Saturating wait-cycle counter; expired_c flags that the next unanswered cycle hits TIMEOUT.
module lsu_timeout_ctr
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired_c
);
   localparam int unsigned CW = ctr_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CW-1:0] count_q;

   // Count unanswered waiting cycles, never wrapping.
   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else if (clear)
         count_q <= '0;
      else if (count_en && (count_q != CNT_MAX))
         count_q <= count_q + CW'(1);
   end

   // The current cycle is the TIMEOUT-th one without a ready.
   always_comb begin
      expired_c = (TIMEOUT != 0) && (count_q >= CNT_LAST);
   end

endmodule

// File: rtl/lsu_param.sv
// Load/store unit: one memory op per request, with timeout and illegal-op error reporting.
module lsu_param
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 8,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned TIMEOUT       = 64,
   parameter logic [2:0]  REQUEST_STATE = CORE_REQUEST,
   parameter logic [2:0]  UPDATE_STATE  = CORE_UPDATE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [2:0]            core_state,
   input  logic                  decoded_mem_read_enable,
   input  logic                  decoded_mem_write_enable,
   input  logic [DATA_WIDTH-1:0] rs,
   input  logic [DATA_WIDTH-1:0] rt,
   lsu_if.master                 mem,
   output logic [2:0]            lsu_state,
   output logic [DATA_WIDTH-1:0] lsu_out,
   output logic                  lsu_error
);
   lsu_state_e            state_q, state_d;
   logic                  op_read_q, op_read_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  wr_valid_q, wr_valid_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0] out_d;
   logic                  error_d;
   logic                  ctr_clear, ctr_en, expired_c;
   logic                  op_ready_c;

   lsu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
      .clk       (clk),
      .reset     (reset),
      .clear     (ctr_clear),
      .count_en  (ctr_en),
      .expired_c (expired_c)
   );

   // Next-state and next-output logic; every register holds unless enabled and updated.
   always_comb begin
      state_d    = state_q;
      op_read_d  = op_read_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rd_valid_d = rd_valid_q;
      rd_addr_d  = rd_addr_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      out_d      = lsu_out;
      ctr_clear  = 1'b0;
      ctr_en     = 1'b0;
      op_ready_c = op_read_q ? mem.mem_read_ready : mem.mem_write_ready;
      if (enable) begin
         case (state_q)
            LSU_IDLE: begin
               if (core_state == REQUEST_STATE) begin
                  if (decoded_mem_read_enable && decoded_mem_write_enable) begin
                     state_d = LSU_ERROR;
                  end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
                     op_read_d = decoded_mem_read_enable;
                     addr_d    = ADDR_WIDTH'(rs);
                     data_d    = rt;
                     state_d   = LSU_REQUESTING;
                  end
               end
            end
            LSU_REQUESTING: begin
               ctr_clear = 1'b1;
               if (op_read_q) begin
                  rd_valid_d = 1'b1;
                  rd_addr_d  = addr_q;
               end else begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = addr_q;
                  wr_data_d  = data_q;
               end
               state_d = LSU_WAITING;
            end
            LSU_WAITING: begin
               if (op_ready_c) begin
                  rd_valid_d = 1'b0;
                  wr_valid_d = 1'b0;
                  if (op_read_q)
                     out_d = mem.mem_read_data;
                  state_d = LSU_DONE;
               end else begin
                  ctr_en = 1'b1;
                  if (expired_c) begin
                     rd_valid_d = 1'b0;
                     wr_valid_d = 1'b0;
                     state_d    = LSU_ERROR;
                  end
               end
            end
            LSU_DONE, LSU_ERROR: begin
               if (core_state == UPDATE_STATE)
                  state_d = LSU_IDLE;
            end
            default: begin
               rd_valid_d = 1'b0;
               wr_valid_d = 1'b0;
               state_d    = LSU_IDLE;
            end
         endcase
      end
      error_d = (state_d == LSU_ERROR);
   end

   // State and output registers; reset aborts any in-flight op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LSU_IDLE;
         op_read_q  <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         lsu_out    <= '0;
         lsu_error  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_read_q  <= op_read_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         lsu_out    <= out_d;
         lsu_error  <= error_d;
      end
   end

   assign lsu_state             = state_q;
   assign mem.mem_read_valid    = rd_valid_q;
   assign mem.mem_read_address  = rd_addr_q;
   assign mem.mem_write_valid   = wr_valid_q;
   assign mem.mem_write_address = wr_addr_q;
   assign mem.mem_write_data    = wr_data_q;

endmodule

// File: tb/tb_lsu_param.sv
// Bench for lsu_param: directed scenarios plus random loads/stores against a transaction model.
module tb_lsu_param;
   import lsu_pkg::*;

   localparam int unsigned TO = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] core_state;
   logic       dec_rd, dec_wr;
   logic [7:0] rs, rt;
   logic [2:0] lsu_state;
   logic [7:0] lsu_out;
   logic       lsu_error;

   int checks = 0;
   int errors = 0;
   logic [7:0] model_out;

   lsu_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) mem_bus ();

   lsu_param #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(TO)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .core_state               (core_state),
      .decoded_mem_read_enable  (dec_rd),
      .decoded_mem_write_enable (dec_wr),
      .rs                       (rs),
      .rt                       (rt),
      .mem                      (mem_bus),
      .lsu_state                (lsu_state),
      .lsu_out                  (lsu_out),
      .lsu_error                (lsu_error)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_bus(input string tag);
      chk({tag, "_rv"}, 32'(mem_bus.mem_read_valid), 32'(0));
      chk({tag, "_wv"}, 32'(mem_bus.mem_write_valid), 32'(0));
   endtask

   // Release DONE/ERROR after a random hold, then confirm return to IDLE.
   task automatic release_to_idle(input string tag, input logic [2:0] held);
      int hold;
      hold = int'($urandom_range(0, 2));
      for (int i = 0; i < hold; i++) begin
         core_state = 3'($urandom_range(0, 5));
         step();
         chk({tag, "_hold"}, 32'(lsu_state), 32'(held));
      end
      core_state = CORE_UPDATE;
      step();
      chk({tag, "_idle"}, 32'(lsu_state), 32'(LSU_IDLE));
      chk({tag, "_errclr"}, 32'(lsu_error), 32'(0));
      core_state = 3'd0;
   endtask

   // One op: issued from IDLE, memory answers after 'waits' unanswered valid cycles.
   task automatic do_op(input string tag, input bit rd, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic [7:0] rdata);
      int  vcyc;
      int  exp_v;
      bit  exp_err;
      exp_err = (waits >= int'(TO));
      exp_v   = exp_err ? int'(TO) : waits + 1;
      core_state = CORE_REQUEST;
      dec_rd = rd;
      dec_wr = !rd;
      rs = a;
      rt = d;
      step();
      chk({tag, "_req"}, 32'(lsu_state), 32'(LSU_REQUESTING));
      chk_idle_bus({tag, "_req"});
      core_state = 3'd0;
      dec_rd = 1'($urandom);
      dec_wr = 1'($urandom);
      rs = 8'($urandom);
      rt = 8'($urandom);
      step();
      vcyc = 0;
      while (lsu_state == 3'(LSU_WAITING) && vcyc < 100) begin
         vcyc++;
         if (rd) begin
            chk({tag, "_rv"}, 32'(mem_bus.mem_read_valid), 32'(1));
            chk({tag, "_wv0"}, 32'(mem_bus.mem_write_valid), 32'(0));
            chk({tag, "_raddr"}, 32'(mem_bus.mem_read_address), 32'(a));
         end else begin
            chk({tag, "_wv"}, 32'(mem_bus.mem_write_valid), 32'(1));
            chk({tag, "_rv0"}, 32'(mem_bus.mem_read_valid), 32'(0));
            chk({tag, "_waddr"}, 32'(mem_bus.mem_write_address), 32'(a));
            chk({tag, "_wdata"}, 32'(mem_bus.mem_write_data), 32'(d));
         end
         if (vcyc == waits + 1) begin
            mem_bus.mem_read_ready  = rd ? 1'b1 : 1'($urandom);
            mem_bus.mem_write_ready = rd ? 1'($urandom) : 1'b1;
            mem_bus.mem_read_data   = rd ? rdata : 8'($urandom);
         end else begin
            mem_bus.mem_read_ready  = rd ? 1'b0 : 1'($urandom);
            mem_bus.mem_write_ready = rd ? 1'($urandom) : 1'b0;
            mem_bus.mem_read_data   = 8'($urandom);
         end
         step();
      end
      mem_bus.mem_read_ready  = 1'b0;
      mem_bus.mem_write_ready = 1'b0;
      if (rd && !exp_err)
         model_out = rdata;
      chk({tag, "_vcycles"}, 32'(vcyc), 32'(exp_v));
      chk({tag, "_end"}, 32'(lsu_state), 32'(exp_err ? LSU_ERROR : LSU_DONE));
      chk({tag, "_err"}, 32'(lsu_error), 32'(exp_err));
      chk({tag, "_out"}, 32'(lsu_out), 32'(model_out));
      chk_idle_bus({tag, "_end"});
      release_to_idle(tag, exp_err ? 3'(LSU_ERROR) : 3'(LSU_DONE));
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      core_state = 3'd0;
      dec_rd = 1'b0;
      dec_wr = 1'b0;
      rs = 8'd0;
      rt = 8'd0;
      mem_bus.mem_read_ready  = 1'b0;
      mem_bus.mem_write_ready = 1'b0;
      mem_bus.mem_read_data   = 8'd0;
      model_out = 8'd0;
      step();
      step();
      chk("rst_state", 32'(lsu_state), 32'(LSU_IDLE));
      chk("rst_out", 32'(lsu_out), 32'(0));
      chk("rst_err", 32'(lsu_error), 32'(0));
      chk("rst_raddr", 32'(mem_bus.mem_read_address), 32'(0));
      chk("rst_waddr", 32'(mem_bus.mem_write_address), 32'(0));
      chk("rst_wdata", 32'(mem_bus.mem_write_data), 32'(0));
      chk_idle_bus("rst");
      reset = 1'b0;

      // Stays idle without a proper request.
      core_state = 3'b001; dec_rd = 1'b1; dec_wr = 1'b0;
      step();
      chk("idle_wrong_stage", 32'(lsu_state), 32'(LSU_IDLE));
      core_state = CORE_REQUEST; dec_rd = 1'b0; dec_wr = 1'b0;
      step();
      chk("idle_no_op", 32'(lsu_state), 32'(LSU_IDLE));
      chk_idle_bus("idle_no_op");

      do_op("load", 1'b1, 8'h2A, 8'h00, 2, 8'h5C);
      do_op("store", 1'b0, 8'h10, 8'hF3, 0, 8'h00);
      do_op("timeout", 1'b1, 8'h33, 8'h00, 10, 8'hEE);

      // Both decoded enables: illegal op.
      core_state = CORE_REQUEST; dec_rd = 1'b1; dec_wr = 1'b1;
      step();
      chk("both_state", 32'(lsu_state), 32'(LSU_ERROR));
      chk("both_err", 32'(lsu_error), 32'(1));
      chk_idle_bus("both");
      core_state = 3'd0; dec_rd = 1'b0; dec_wr = 1'b0;
      step();
      chk_idle_bus("both_next");
      release_to_idle("both", 3'(LSU_ERROR));

      // Freeze mid-wait with ready asserted; counter must not advance either.
      core_state = CORE_REQUEST; dec_rd = 1'b1; rs = 8'h44;
      step();
      core_state = 3'd0; dec_rd = 1'b0;
      step();
      step();
      enable = 1'b0;
      mem_bus.mem_read_ready = 1'b1;
      mem_bus.mem_read_data  = 8'h99;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("frz_state", 32'(lsu_state), 32'(LSU_WAITING));
         chk("frz_rv", 32'(mem_bus.mem_read_valid), 32'(1));
      end
      enable = 1'b1;
      mem_bus.mem_read_ready = 1'b0;
      step();
      step();
      chk("frz_resume", 32'(lsu_state), 32'(LSU_WAITING));
      mem_bus.mem_read_ready = 1'b1;
      mem_bus.mem_read_data  = 8'h77;
      step();
      mem_bus.mem_read_ready = 1'b0;
      model_out = 8'h77;
      chk("frz_done", 32'(lsu_state), 32'(LSU_DONE));
      chk("frz_out", 32'(lsu_out), 32'(model_out));
      release_to_idle("frz", 3'(LSU_DONE));

      // Random traffic against the transaction model.
      for (int n = 0; n < 24; n++) begin
         do_op("rand", 1'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, 6)), 8'($urandom));
      end

      // Reset while waiting aborts the op.
      core_state = CORE_REQUEST; dec_rd = 1'b1; rs = 8'h5A;
      step();
      core_state = 3'd0; dec_rd = 1'b0;
      step();
      chk("rstw_waiting", 32'(lsu_state), 32'(LSU_WAITING));
      reset = 1'b1;
      step();
      chk("rstw_state", 32'(lsu_state), 32'(LSU_IDLE));
      chk("rstw_out", 32'(lsu_out), 32'(0));
      chk("rstw_raddr", 32'(mem_bus.mem_read_address), 32'(0));
      chk_idle_bus("rstw");
      reset = 1'b0;
      step();
      chk_idle_bus("rstw_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_param.md
LSU_PARAM -- requirements
Module: lsu_param

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the memory and register data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, the maximum WAITING cycles before error; 0 disables the timeout.
REQ-004 SHALL have parameter REQUEST_STATE, default 3'b011, the core_state value that starts a request.
REQ-005 SHALL have parameter UPDATE_STATE, default 3'b110, the core_state value that releases DONE or ERROR.
REQ-006 SHALL have ports, one per line:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  thread active; low freezes all state and outputs.
- core_state  in  3  core pipeline stage.
- decoded_mem_read_enable  in  1  LDR.
- decoded_mem_write_enable  in  1  STR.
- rs  in  DATA_WIDTH  address source; low ADDR_WIDTH bits used, zero-extended if ADDR_WIDTH > DATA_WIDTH.
- rt  in  DATA_WIDTH  store data.
- mem_read_valid  out  1  read request.
- mem_read_address  out  ADDR_WIDTH  read address.
- mem_read_ready  in  1  read done; data valid.
- mem_read_data  in  DATA_WIDTH  read data.
- mem_write_valid  out  1  write request.
- mem_write_address  out  ADDR_WIDTH  write address.
- mem_write_data  out  DATA_WIDTH  write data.
- mem_write_ready  in  1  write accepted.
- lsu_state  out  3  IDLE=0, REQUESTING=1, WAITING=2, DONE=3, ERROR=4.
- lsu_out  out  DATA_WIDTH  last load result.
- lsu_error  out  1  high while in ERROR.

Function
REQ-007 SHALL register all outputs; no combinational input-to-output paths.
REQ-008 IDLE: with enable=1 and core_state==REQUEST_STATE, exactly one decoded enable high -> latch op (read/write), rs, rt; go to REQUESTING.
REQ-009 IDLE: both decoded enables high at REQUEST_STATE -> go to ERROR; no memory request issued.
REQ-010 IDLE: neither enable high, or core_state != REQUEST_STATE -> remain IDLE.
REQ-011 REQUESTING (1 cycle): assert the latched op's valid and drive its address (plus write_data for a store); clear the timeout counter; go to WAITING.
REQ-012 WAITING: sample only the ready of the latched op; ready=1 -> deassert valid; for a read, capture mem_read_data into lsu_out; go to DONE.
REQ-013 A ready in the first WAITING cycle SHALL be accepted, giving a minimum latency of 3 cycles from the IDLE request edge to DONE.
REQ-014 WAITING without ready: increment the counter; when TIMEOUT != 0 and the counter reaches TIMEOUT without ready -> deassert valid, go to ERROR, lsu_out unchanged.
REQ-015 Counter width SHALL be $clog2(TIMEOUT+1), minimum 1; the counter SHALL not wrap.
REQ-016 DONE and ERROR: hold until core_state==UPDATE_STATE, then go to IDLE; lsu_error clears on that transition.
REQ-017 Changes on decoded enables, rs or rt after latching SHALL not affect the in-flight op.
REQ-018 The read and write valid signals SHALL never be high simultaneously.
REQ-019 Address, data and valid outputs SHALL be stable while valid is high.
REQ-020 enable=0 SHALL hold the state, counter and outputs, including an asserted valid.
REQ-021 A store SHALL not modify lsu_out.

Reset
REQ-022 Reset SHALL set: lsu_state=IDLE; lsu_out, all addresses, write_data, counter and latched regs = 0; valids = 0; lsu_error = 0.
REQ-023 Reset SHALL take priority over enable and SHALL abort any in-flight op at the next edge with no further valid.

Structure
REQ-024 A shared package lsu_pkg SHALL hold the lsu_state enum (3-bit) and the core-state constants REQUEST/UPDATE.
REQ-025 The timeout counter SHALL be one sub-module, lsu_timeout_ctr, with clear, count-enable and expired inputs/outputs.

Verification
REQ-026 Load: rs=0x2A, REQUEST_STATE, ready after 2 waits with data 0x5C -> read_valid high 3 cycles, read_address=0x2A, lsu_out=0x5C, DONE; UPDATE_STATE -> IDLE.
REQ-027 Store: rs=0x10, rt=0xF3, ready in the first WAITING cycle -> write_address=0x10, write_data=0xF3, write_valid high 1 cycle, lsu_out unchanged.
REQ-028 Timeout with TIMEOUT=4 and ready held low -> valid drops and ERROR/lsu_error=1 after exactly 4 WAITING cycles; UPDATE_STATE clears to IDLE.
REQ-029 Both decoded enables high at REQUEST_STATE -> ERROR next cycle, both valids remain 0.
REQ-030 enable=0 for 5 cycles mid-WAITING, with ready asserted -> ready ignored, state held; completes after enable returns.
REQ-031 Reset asserted in WAITING -> next cycle IDLE, valids 0, lsu_out 0.
